// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcodes and the multiply sequencer state.
package cpu_types_pkg;

  localparam int WORD_BITS  = 32;
  localparam int MULT_CNT_W = 6;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

endpackage

// File: rtl/alu_mult_exit_shift.sv
// Logical right barrel shifter used for the multiplier early-exit path.
// Only instantiated when MULT_EARLY_EXIT_EN is defined.
module alu_mult_exit_shift #(
  parameter int DATA_W = 64,
  parameter int SH_W   = 7
) (
  input  logic [DATA_W-1:0] din,
  input  logic [SH_W-1:0]   shamt,
  output logic [DATA_W-1:0] dout
);

  // Zero-filling right shift by a run-time amount.
  assign dout = din >> shamt;

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned WORD_W x WORD_W multiply sequencer that borrows the
// shared ALU for its additions (carry recovered with a follow-up SLTU).
// Optional feature: define MULT_EARLY_EXIT_EN to retire the remaining shifts
// in one cycle once the multiplier has no set bits left.
module alu_mult_seq
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = $bits(word_t),
  parameter int CNT_W  = MULT_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_hi,
  output logic [WORD_W-1:0] rsp_lo,
  output logic              alu_busy,
  output aluop_t            alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_o
);

  mult_state_t       state, state_n;
  logic [WORD_W-1:0] mcand, mcand_n;
  logic [WORD_W-1:0] mplier, mplier_n;
  logic [WORD_W-1:0] hi, hi_n;
  logic [WORD_W-1:0] lo, lo_n;
  logic [WORD_W-1:0] sum_r, sum_r_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

`ifdef MULT_EARLY_EXIT_EN
  logic [CNT_W:0]      exit_shamt;
  logic [2*WORD_W-1:0] exit_dout;

  // Shift that aligns the product once no multiplier bits remain.
  assign exit_shamt = (CNT_W+1)'(WORD_W) - {1'b0, cnt};

  alu_mult_exit_shift #(
    .DATA_W (2*WORD_W),
    .SH_W   (CNT_W+1)
  ) u_exit_shift (
    .din   ({hi, lo}),
    .shamt (exit_shamt),
    .dout  (exit_dout)
  );
`endif

  // Response data is the product registers directly; rsp_valid qualifies it.
  assign rsp_hi = hi;
  assign rsp_lo = lo;

  // Next-state, datapath update and ALU drive for the shift-add sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_n   = state;
    mcand_n   = mcand;
    mplier_n  = mplier;
    hi_n      = hi;
    lo_n      = lo;
    sum_r_n   = sum_r;
    cnt_n     = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_busy  = 1'b0;
    alu_op    = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mcand_n  = req_a;
          mplier_n = req_b;
          hi_n     = '0;
          lo_n     = '0;
          cnt_n    = '0;
          state_n  = STEP;
        end
      end

      STEP: begin
        alu_busy = 1'b1;
        alu_op   = ALU_ADD;
        alu_a    = hi;
        alu_b    = mcand;
        if (cnt == CNT_W'(WORD_W)) begin
          state_n = DONE;
`ifdef MULT_EARLY_EXIT_EN
        end else if (mplier == '0) begin
          // Remaining iterations are all plain shifts; do them at once and
          // let the counter check retire the operation next cycle.
          {hi_n, lo_n} = exit_dout;
          cnt_n        = CNT_W'(WORD_W);
`endif
        end else if (!mplier[0]) begin
          {hi_n, lo_n} = {1'b0, hi, lo[WORD_W-1:1]};
          mplier_n     = mplier >> 1;
          cnt_n        = cnt + 1'b1;
        end else begin
          sum_r_n = alu_o;
          state_n = CARRY;
        end
      end

      CARRY: begin
        // sum_r < mcand exactly when hi + mcand wrapped, i.e. the add carried.
        alu_busy     = 1'b1;
        alu_op       = ALU_SLTU;
        alu_a        = sum_r;
        alu_b        = mcand;
        {hi_n, lo_n} = {alu_o[0], sum_r, lo[WORD_W-1:1]};
        mplier_n     = mplier >> 1;
        cnt_n        = cnt + 1'b1;
        state_n      = STEP;
      end

      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: the datapath registers are reset too, since rsp_hi/rsp_lo read them directly and must come up zero.
    if (!nRST) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      sum_r  <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      hi     <= hi_n;
      lo     <= lo_n;
      sum_r  <= sum_r_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: directed cases plus random operand
// pairs compared against a plain-arithmetic reference for product and latency.
module tb_alu_mult_seq;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        alu_busy;
  aluop_t      alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_o;

  int total = 0;
  int bad   = 0;

  alu_mult_seq dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hi    (rsp_hi),
    .rsp_lo    (rsp_lo),
    .alu_busy  (alu_busy),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_o     (alu_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU stand-in: only the two operations the sequencer uses.
  always_comb begin
    alu_o = '0;
    case (alu_op)
      ALU_ADD:  alu_o = alu_a + alu_b;
      ALU_SLTU: alu_o = {31'b0, (alu_a < alu_b)};
      default:  alu_o = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycles from the accept edge to rsp_valid, from the bit pattern of b.
  function automatic int ref_latency(input logic [31:0] b);
    int pop;
    int msb;
    pop = 0;
    msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        pop++;
        msb = i;
      end
    end
`ifdef MULT_EARLY_EXIT_EN
    if (b == 0) return 2;
    if (msb == 31) return 32 + pop + 1;
    return msb + 1 + pop + 2;
`else
    return 32 + pop + 1;
`endif
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    nRST = 1'b0;
    repeat (cycles) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_prod", {rsp_hi, rsp_lo}, 64'd0);
    check("rst_alu_busy", alu_busy, 0);
    check("rst_alu_drive", {28'd0, alu_op, alu_a, alu_b}, {28'd0, ALU_ADD, 32'd0, 32'd0});
    nRST = 1'b1;
  endtask

  // Present one operand pair at a negedge; returns after the accept edge.
  task automatic start_req(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp_p;
    int          lat;
    bit          busy_ok;
    bit          hold_ok;
    exp_p   = {32'd0, a} * {32'd0, b};
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat     = 0;
    start_req(a, b);
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (!rsp_valid && !alu_busy) busy_ok = 1'b0;
    end while (!rsp_valid && lat < 200);
    check("latency", lat, ref_latency(b));
    check("product", {rsp_hi, rsp_lo}, exp_p);
    check("busy_while_running", busy_ok, 1);
    check("done_alu_busy", alu_busy, 0);
    check("done_req_ready", req_ready, 0);
    repeat (hold) begin
      @(negedge CLK);
      if (!rsp_valid || req_ready || {rsp_hi, rsp_lo} !== exp_p) hold_ok = 1'b0;
    end
    if (hold > 0) check("held_stable", hold_ok, 1);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    check("after_take_valid", rsp_valid, 0);
    check("after_take_ready", req_ready, 1);
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset(2);

    run_op(32'd3, 32'd5, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(32'h80000000, 32'd2, 0);
    run_op(32'd7, 32'd6, 10);
    run_op(32'h12345678, 32'd0, 1);

    // Reset in the middle of an operation discards it.
    start_req(32'd9, 32'd9);
    repeat (9) @(posedge CLK);
    #1;
    check("mid_op_busy", alu_busy, 1);
    do_reset(2);
    run_op(32'd2, 32'd3, 0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom & $urandom & $urandom;
        2:       b = $urandom_range(0, 255);
        default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFFFFFF;
      endcase
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
